// File: rtl/fib_stream_gen_if.sv
// Handshake bundle for fib_stream_gen: sequence request inputs and the
// valid/ready term stream with status flags.
interface fib_stream_gen_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] fib_out;
    logic [CNT_W-1:0] term_idx;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, n, seed0, seed1, out_ready,
        input  out_valid, fib_out, term_idx, busy, done, overflow
    );

    modport slave (
        input  start, n, seed0, seed1, out_ready,
        output out_valid, fib_out, term_idx, busy, done, overflow
    );
endinterface

// File: rtl/fib_stream_gen.sv
// Streams terms 0..n of a seeded Fibonacci recurrence over a valid/ready
// port, stopping early (with a sticky overflow flag) when a term exceeds WIDTH bits.
module fib_stream_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    fib_stream_gen_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_curr;
    logic             r_carry;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_n;
    logic             r_overflow;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH:0]   w_sum;

    // One extra bit so the carry-out marks a next term that does not fit
    assign w_sum = {1'b0, r_prev} + {1'b0, r_curr};

    // Sequence FSM; status outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_prev      <= {WIDTH{1'b0}};
            r_curr      <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_idx       <= {CNT_W{1'b0}};
            r_n         <= {CNT_W{1'b0}};
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_n         <= bus.n;
                        r_prev      <= bus.seed0;
                        r_curr      <= bus.seed1;
                        r_carry     <= 1'b0;
                        r_idx       <= {CNT_W{1'b0}};
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.out_ready) begin
                        if (r_idx == r_n) begin
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (r_carry) begin
                            // Next term would not fit: stop before emitting it
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_overflow  <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_prev  <= r_curr;
                            r_carry <= w_sum[WIDTH];
                            r_curr  <= w_sum[WIDTH-1:0];
                            r_idx   <= r_idx + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.fib_out   = r_prev;
    assign bus.term_idx  = r_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen: a vector table for short sequences plus
// hand-written runs for stalls, 8-bit overflow, start-in-RUN and mid-run reset.
module tb_fib_stream_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fib_stream_gen_if #(.WIDTH(32), .CNT_W(8)) b32 ();
    fib_stream_gen_if #(.WIDTH(8),  .CNT_W(8)) b8 ();

    fib_stream_gen #(.WIDTH(32), .CNT_W(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    fib_stream_gen #(.WIDTH(8),  .CNT_W(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  n;
        logic [31:0] s0;
        logic [31:0] s1;
        logic        rdy;
        logic        v;
        logic [31:0] fib;
        logic [7:0]  idx;
        logic        busy;
        logic        done;
        logic        ovf;
    } vec_t;

    vec_t        tbl[14];
    int          fib_exp[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic start32(input logic [7:0] n, input logic [31:0] s0, input logic [31:0] s1);
        b32.start = 1'b1;
        b32.n     = n;
        b32.seed0 = s0;
        b32.seed1 = s1;
    endtask

    initial begin
        int          k;
        int          cyc;
        bit          got_done;
        bit          stall;
        bit          rdy;
        logic [31:0] p_fib;
        logic [7:0]  p_idx;
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] mt;
        logic [31:0] last_fib;
        logic [7:0]  last_idx;

        checks = 0;
        errors = 0;
        b32.start = 1'b0; b32.n = 8'd0; b32.seed0 = 32'd0; b32.seed1 = 32'd0; b32.out_ready = 1'b1;
        b8.start  = 1'b0; b8.n  = 8'd0; b8.seed0  = 8'd0;  b8.seed1  = 8'd0;  b8.out_ready  = 1'b1;
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", b32.out_valid, 1'b0);
        chk("rst_fib",   b32.fib_out,   32'd0);
        chk("rst_idx",   b32.term_idx,  8'd0);
        chk("rst_busy",  b32.busy,      1'b0);
        chk("rst_done",  b32.done,      1'b0);
        chk("rst_ovf",   b32.overflow,  1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Lucas 2/1 n=4, ignored start in DONE, back-to-back n=0, then n=1
        tbl[0]  = '{1'b1, 8'd4, 32'd2,  32'd1,  1'b1, 1'b1, 32'd2, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b1, 32'd1, 8'd1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b1, 32'd3, 8'd2, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b1, 32'd4, 8'd3, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b1, 32'd7, 8'd4, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b0, 32'd7, 8'd4, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'd3, 32'd50, 32'd60, 1'b1, 1'b0, 32'd7, 8'd4, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'd0, 32'd9,  32'd5,  1'b1, 1'b1, 32'd9, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b0, 32'd9, 8'd0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b0, 32'd9, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'd1, 32'd7,  32'd8,  1'b1, 1'b1, 32'd7, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b1, 32'd8, 8'd1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b0, 32'd8, 8'd1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'd0, 32'd0,  32'd0,  1'b1, 1'b0, 32'd8, 8'd1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            b32.start = tbl[i].start; b32.n = tbl[i].n;
            b32.seed0 = tbl[i].s0; b32.seed1 = tbl[i].s1; b32.out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), b32.out_valid, tbl[i].v);
            chk($sformatf("tbl%0d_fib", i),   b32.fib_out,   tbl[i].fib);
            chk($sformatf("tbl%0d_idx", i),   b32.term_idx,  tbl[i].idx);
            chk($sformatf("tbl%0d_busy", i),  b32.busy,      tbl[i].busy);
            chk($sformatf("tbl%0d_done", i),  b32.done,      tbl[i].done);
            chk($sformatf("tbl%0d_ovf", i),   b32.overflow,  tbl[i].ovf);
        end

        // Seeds 0/1, n=10, always ready
        start32(8'd10, 32'd0, 32'd1);
        b32.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            b32.start = 1'b0;
            chk("seq_valid", b32.out_valid, 1'b1);
            chk("seq_fib",   b32.fib_out,   fib_exp[i]);
            chk("seq_idx",   b32.term_idx,  i);
        end
        @(negedge clk);
        chk("seq_done",      b32.done,      1'b1);
        chk("seq_done_v",    b32.out_valid, 1'b0);
        chk("seq_ovf",       b32.overflow,  1'b0);
        @(negedge clk);
        chk("seq_idle_done", b32.done,      1'b0);
        chk("seq_idle_busy", b32.busy,      1'b0);
        chk("seq_hold_fib",  b32.fib_out,   32'd55);
        chk("seq_hold_idx",  b32.term_idx,  8'd10);

        // Same sequence with out_ready pattern 1,0,0,1,0,0,...
        start32(8'd10, 32'd0, 32'd1);
        @(negedge clk);
        b32.start = 1'b0;
        k = 0; cyc = 0; got_done = 1'b0; stall = 1'b0; p_fib = 32'd0; p_idx = 8'd0;
        while (!got_done && cyc < 200) begin
            if (b32.done) begin
                got_done = 1'b1;
            end else if (b32.out_valid) begin
                if (stall) begin
                    chk("stall_fib_hold", b32.fib_out,  p_fib);
                    chk("stall_idx_hold", b32.term_idx, p_idx);
                end
                rdy = (cyc % 3 == 0);
                b32.out_ready = rdy;
                if (rdy) begin
                    chk("stall_term", b32.fib_out, (k < 11) ? fib_exp[k] : 32'hFFFFFFFF);
                    chk("stall_idx",  b32.term_idx, k);
                    k++;
                end
                stall = !rdy;
                p_fib = b32.fib_out;
                p_idx = b32.term_idx;
            end
            if (!got_done) @(negedge clk);
            cyc++;
        end
        chk("stall_got_done", got_done, 1'b1);
        chk("stall_count",    k, 11);
        chk("stall_ovf",      b32.overflow, 1'b0);
        b32.out_ready = 1'b1;
        @(negedge clk);

        // 8-bit overflow: seeds 0/1, n=20
        b8.start = 1'b1; b8.n = 8'd20; b8.seed0 = 8'd0; b8.seed1 = 8'd1; b8.out_ready = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        ma = 64'd0; mb = 64'd1; k = 0; cyc = 0; got_done = 1'b0;
        last_fib = 32'd0; last_idx = 8'd0;
        while (!got_done && cyc < 60) begin
            if (b8.done) begin
                got_done = 1'b1;
            end else if (b8.out_valid) begin
                chk("w8_term", b8.fib_out, ma);
                chk("w8_idx",  b8.term_idx, k);
                last_fib = 32'(b8.fib_out);
                last_idx = b8.term_idx;
                mt = ma + mb; ma = mb; mb = mt;
                k++;
            end
            if (!got_done) @(negedge clk);
            cyc++;
        end
        chk("w8_got_done", got_done, 1'b1);
        chk("w8_last_fib", last_fib, 32'd233);
        chk("w8_last_idx", last_idx, 8'd13);
        chk("w8_ovf",      b8.overflow, 1'b1);
        @(negedge clk);
        chk("w8_ovf_sticky", b8.overflow, 1'b1);
        chk("w8_idle_busy",  b8.busy,     1'b0);
        b8.start = 1'b1; b8.n = 8'd0; b8.seed0 = 8'd4; b8.seed1 = 8'd4;
        @(negedge clk);
        b8.start = 1'b0;
        chk("w8_ovf_clr", b8.overflow, 1'b0);
        chk("w8_n0_fib",  b8.fib_out,  8'd4);

        // start ignored mid-RUN, then reset at term_idx=5
        repeat (3) @(negedge clk);
        start32(8'd10, 32'd0, 32'd1);
        @(negedge clk);
        b32.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("mid_fib", b32.fib_out,  fib_exp[i]);
            chk("mid_idx", b32.term_idx, i);
            if (i == 2) start32(8'd3, 32'd77, 32'd88);
            @(negedge clk);
        end
        chk("mid_fib5", b32.fib_out,  32'd5);
        chk("mid_idx5", b32.term_idx, 8'd5);
        rst = 1'b1;
        #1;
        chk("arst_valid", b32.out_valid, 1'b0);
        chk("arst_busy",  b32.busy,      1'b0);
        chk("arst_fib",   b32.fib_out,   32'd0);
        chk("arst_idx",   b32.term_idx,  8'd0);
        chk("arst_done",  b32.done,      1'b0);
        b32.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start32(8'd1, 32'd3, 32'd4);
        @(negedge clk);
        b32.start = 1'b0;
        chk("post_rst_done",  b32.done,      1'b0);
        chk("post_rst_valid", b32.out_valid, 1'b1);
        chk("post_rst_fib",   b32.fib_out,   32'd3);
        @(negedge clk);
        chk("post_rst_fib1",  b32.fib_out,   32'd4);
        @(negedge clk);
        chk("post_rst_end",   b32.done,      1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/fib_stream_gen.md
FIB_STREAM_GEN -- requirements
Module: fib_stream_gen

Interface
REQ-001 Parameter WIDTH, default 32, term width in bits.
REQ-002 Parameter CNT_W, default 8, term-index and term-count width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high; clears all state immediately when asserted.
REQ-005 start  input  1  request a new sequence; sampled only in IDLE.
REQ-006 n  input  CNT_W  index of last term to emit; captured on accepted start.
REQ-007 seed0  input  WIDTH  term 0; captured on accepted start.
REQ-008 seed1  input  WIDTH  term 1; captured on accepted start.
REQ-009 out_ready  input  1  downstream accepts the current term.
REQ-010 out_valid  output  1  fib_out and term_idx hold a valid term.
REQ-011 fib_out  output  WIDTH  current term value.
REQ-012 term_idx  output  CNT_W  index of the current term.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 done  output  1  one-cycle pulse at sequence end.
REQ-015 overflow  output  1  sticky until next accepted start: sequence stopped on WIDTH overflow.

Function
REQ-016 The block SHALL implement the FSM IDLE, RUN and DONE.
REQ-017 In IDLE with start=1, the block SHALL capture n, seed0 and seed1 and set prev=seed0, curr=seed1, carry=0, idx=0 and overflow=0, then enter RUN.
REQ-018 out_valid SHALL first rise on the cycle after start is sampled, giving a latency of 1.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 In RUN, the block SHALL drive out_valid=1, fib_out=prev and term_idx=idx.
REQ-021 out_valid, fib_out and term_idx SHALL stay stable while out_ready=0.
REQ-022 A term is accepted on a cycle with out_valid=1 and out_ready=1, and each accepted term SHALL be evaluated in priority order:
  (a) idx==n: enter DONE;
  (b) carry==1: enter DONE and set overflow=1;
  (c) otherwise: prev<=curr, {carry,curr}<=prev+curr with a (WIDTH+1)-bit sum, idx<=idx+1.
REQ-023 carry SHALL mark a curr value that is not representable in WIDTH bits; such a term SHALL never be emitted.
REQ-024 With n=0, exactly one term (seed0) SHALL be emitted.
REQ-025 With n=1, exactly two terms (seed0, seed1) SHALL be emitted.
REQ-026 idx SHALL NOT wrap, because the block terminates at idx==n.
REQ-027 In DONE, the block SHALL hold out_valid=0 and done=1 for exactly one cycle, then enter IDLE.
REQ-028 A start asserted during the DONE cycle SHALL be ignored.
REQ-029 Back-to-back sequences SHALL be supported: a start in the first IDLE cycle after DONE is accepted.
REQ-030 In IDLE, fib_out and term_idx SHALL hold their last values, and out_valid SHALL be 0.

Reset
REQ-031 While rst=1, all registers SHALL clear asynchronously: state=IDLE, prev=0, curr=0, carry=0, idx=0, captured n=0 and overflow=0.
REQ-032 While rst=1, all outputs SHALL be 0.
REQ-033 Reset asserted mid-RUN SHALL abort the sequence with no done pulse, and overflow SHALL be cleared.
REQ-034 After rst deasserts, the block SHALL be in IDLE and SHALL accept start on the first subsequent rising edge.

Verification
REQ-035 WIDTH=32, seeds 0/1, n=10, out_ready=1 -> fib_out 0,1,1,2,3,5,8,13,21,34,55 on 11 consecutive cycles; term_idx 0..10; done on the following cycle; overflow=0.
REQ-036 Same sequence with out_ready toggling 1,0,0,1,... -> identical term list with no duplicates or skips, and outputs held stable during stalls.
REQ-037 WIDTH=8, seeds 0/1, n=20 -> last term emitted is 233 at term_idx=13; done pulses; overflow=1; 377 is never emitted.
REQ-038 Lucas seeds 2/1, n=4 -> 2,1,3,4,7; then n=0 with seeds 9/5 started in the cycle after the done pulse -> single term 9, then done.
REQ-039 Assert start mid-RUN -> ignored with the sequence unchanged; assert rst at term_idx=5 -> next cycle out_valid=0, busy=0 and no done pulse.
